// File: rtl/roi_window_detector.sv
`default_nettype none
// ============================================================================
// Module      : roi_window_detector
// Description : Finds the bounding box of the first run of qualifying rows in
//               a binarised pixel stream. Each row is active when its white
//               pixel count reaches a runtime threshold. The first run of at
//               least MIN_RUN consecutive active rows is reported, together
//               with the largest per-row white count and the row holding it.
//               Results are held for readout until acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module roi_window_detector #(
  parameter int IMG_W   = 320,
  parameter int IMG_H   = 240,
  parameter int MIN_RUN = 4,
  parameter int COL_W   = $clog2(IMG_W),
  parameter int ROW_W   = $clog2(IMG_H),
  parameter int CNT_W   = $clog2(IMG_W + 1)
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iStart,
  input  logic             iAck,
  input  logic             iNewFrame,
  input  logic             iDATA,
  input  logic             iDVAL,
  input  logic [CNT_W-1:0] iThreshold,
  output logic [1:0]       oState,
  output logic             oDone,
  output logic             oFound,
  output logic [ROW_W-1:0] oTop,
  output logic [ROW_W-1:0] oBottom,
  output logic [COL_W-1:0] oLeft,
  output logic [COL_W-1:0] oRight,
  output logic [CNT_W-1:0] oMaxCount,
  output logic [ROW_W-1:0] oMaxRow
);

  // Run length only needs to reach MIN_RUN; it saturates there.
  localparam int RUN_W = $clog2(MIN_RUN + 1);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] SAT_CNT  = CNT_W'(IMG_W);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MIN_RUN);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    WAIT_FRAME = 2'b01,
    SCAN       = 2'b10,
    DONE       = 2'b11
  } state_t;

  state_t state;
  logic   start_d;
  logic   finishing;    // final pixel accepted; results publish next edge

  // Per-row accumulators
  logic [COL_W-1:0] col, nxt_col;
  logic [ROW_W-1:0] row, nxt_row;
  logic [CNT_W-1:0] count, nxt_count;
  logic             has_white, nxt_has;
  logic [COL_W-1:0] row_min, nxt_min;
  logic [COL_W-1:0] row_max, nxt_max;

  // Open candidate run
  logic [RUN_W-1:0] run_len, nxt_run;
  logic [ROW_W-1:0] cand_top, nxt_top;
  logic [ROW_W-1:0] cand_bottom, nxt_bottom;
  logic [COL_W-1:0] cand_left, nxt_left;
  logic [COL_W-1:0] cand_right, nxt_right;
  logic             cand_cols, nxt_cols;   // candidate holds at least one white column

  // First qualifying run, frozen once locked
  logic             locked, nxt_locked;
  logic [ROW_W-1:0] lock_top, nxt_lock_top;
  logic [ROW_W-1:0] lock_bottom, nxt_lock_bottom;
  logic [COL_W-1:0] lock_left, nxt_lock_left;
  logic [COL_W-1:0] lock_right, nxt_lock_right;

  // Brightest row so far
  logic [CNT_W-1:0] best, nxt_best;
  logic [ROW_W-1:0] best_row, nxt_best_row;

  logic             restart;
  logic             accept;
  logic             frame_end;
  logic [CNT_W-1:0] pix_cnt;
  logic             pix_has;
  logic [COL_W-1:0] pix_min;
  logic [COL_W-1:0] pix_max;
  logic             active;
  logic             last_row;

  assign oState = state;
  assign oDone  = (state == DONE);

  // Next-state datapath: optional frame restart, then pixel accumulation and row evaluation
  always_comb begin
    restart   = iNewFrame && ((state == WAIT_FRAME) || (state == SCAN && !finishing));
    accept    = iDVAL && (restart || (state == SCAN && !finishing));
    frame_end = 1'b0;
    pix_cnt   = '0;
    pix_has   = 1'b0;
    pix_min   = '0;
    pix_max   = '0;
    active    = 1'b0;
    last_row  = 1'b0;

    nxt_col         = col;
    nxt_row         = row;
    nxt_count       = count;
    nxt_has         = has_white;
    nxt_min         = row_min;
    nxt_max         = row_max;
    nxt_run         = run_len;
    nxt_top         = cand_top;
    nxt_bottom      = cand_bottom;
    nxt_left        = cand_left;
    nxt_right       = cand_right;
    nxt_cols        = cand_cols;
    nxt_locked      = locked;
    nxt_lock_top    = lock_top;
    nxt_lock_bottom = lock_bottom;
    nxt_lock_left   = lock_left;
    nxt_lock_right  = lock_right;
    nxt_best        = best;
    nxt_best_row    = best_row;

    // A new frame wipes every accumulator; the same cycle's pixel is (0,0).
    if (restart) begin
      nxt_col         = '0;
      nxt_row         = '0;
      nxt_count       = '0;
      nxt_has         = 1'b0;
      nxt_min         = '0;
      nxt_max         = '0;
      nxt_run         = '0;
      nxt_top         = '0;
      nxt_bottom      = '0;
      nxt_left        = '0;
      nxt_right       = '0;
      nxt_cols        = 1'b0;
      nxt_locked      = 1'b0;
      nxt_lock_top    = '0;
      nxt_lock_bottom = '0;
      nxt_lock_left   = '0;
      nxt_lock_right  = '0;
      nxt_best        = '0;
      nxt_best_row    = '0;
    end

    if (accept) begin
      pix_cnt = (iDATA && nxt_count != SAT_CNT) ? nxt_count + CNT_W'(1) : nxt_count;
      pix_has = nxt_has | iDATA;
      pix_min = (iDATA && !nxt_has) ? nxt_col : nxt_min;
      pix_max = iDATA ? nxt_col : nxt_max;

      if (nxt_col != LAST_COL) begin
        nxt_col   = nxt_col + COL_W'(1);
        nxt_count = pix_cnt;
        nxt_has   = pix_has;
        nxt_min   = pix_min;
        nxt_max   = pix_max;
      end else begin
        // Row complete, including this pixel
        active   = (pix_cnt >= iThreshold);
        last_row = (nxt_row == LAST_ROW);

        if (pix_cnt > nxt_best) begin
          nxt_best     = pix_cnt;
          nxt_best_row = nxt_row;
        end

        if (active) begin
          if (nxt_run == '0) nxt_top = nxt_row;
          if (nxt_run != RUN_MAX) nxt_run = nxt_run + RUN_W'(1);
          nxt_bottom = nxt_row;
          if (pix_has) begin
            if (!nxt_cols || pix_min < nxt_left)  nxt_left  = pix_min;
            if (!nxt_cols || pix_max > nxt_right) nxt_right = pix_max;
            nxt_cols = 1'b1;
          end
          // A run still open at the bottom of the frame qualifies too.
          if (!nxt_locked && last_row && nxt_run == RUN_MAX) begin
            nxt_locked      = 1'b1;
            nxt_lock_top    = nxt_top;
            nxt_lock_bottom = nxt_bottom;
            nxt_lock_left   = nxt_left;
            nxt_lock_right  = nxt_right;
          end
        end else begin
          if (!nxt_locked && nxt_run == RUN_MAX) begin
            nxt_locked      = 1'b1;
            nxt_lock_top    = nxt_top;
            nxt_lock_bottom = nxt_bottom;
            nxt_lock_left   = nxt_left;
            nxt_lock_right  = nxt_right;
          end
          nxt_run    = '0;
          nxt_top    = '0;
          nxt_bottom = '0;
          nxt_left   = '0;
          nxt_right  = '0;
          nxt_cols   = 1'b0;
        end

        nxt_col   = '0;
        nxt_row   = last_row ? '0 : nxt_row + ROW_W'(1);
        nxt_count = '0;
        nxt_has   = 1'b0;
        nxt_min   = '0;
        nxt_max   = '0;
        frame_end = last_row;
      end
    end
  end

  // Datapath registers simply follow the computed next state
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      col         <= '0;
      row         <= '0;
      count       <= '0;
      has_white   <= 1'b0;
      row_min     <= '0;
      row_max     <= '0;
      run_len     <= '0;
      cand_top    <= '0;
      cand_bottom <= '0;
      cand_left   <= '0;
      cand_right  <= '0;
      cand_cols   <= 1'b0;
      locked      <= 1'b0;
      lock_top    <= '0;
      lock_bottom <= '0;
      lock_left   <= '0;
      lock_right  <= '0;
      best        <= '0;
      best_row    <= '0;
    end else begin
      col         <= nxt_col;
      row         <= nxt_row;
      count       <= nxt_count;
      has_white   <= nxt_has;
      row_min     <= nxt_min;
      row_max     <= nxt_max;
      run_len     <= nxt_run;
      cand_top    <= nxt_top;
      cand_bottom <= nxt_bottom;
      cand_left   <= nxt_left;
      cand_right  <= nxt_right;
      cand_cols   <= nxt_cols;
      locked      <= nxt_locked;
      lock_top    <= nxt_lock_top;
      lock_bottom <= nxt_lock_bottom;
      lock_left   <= nxt_lock_left;
      lock_right  <= nxt_lock_right;
      best        <= nxt_best;
      best_row    <= nxt_best_row;
    end
  end

  // Control FSM and registered result outputs
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= IDLE;
      start_d   <= 1'b0;
      finishing <= 1'b0;
      oFound    <= 1'b0;
      oTop      <= '0;
      oBottom   <= '0;
      oLeft     <= '0;
      oRight    <= '0;
      oMaxCount <= '0;
      oMaxRow   <= '0;
    end else begin
      start_d <= iStart;
      case (state)
        IDLE: begin
          if (iStart && !start_d) state <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          finishing <= 1'b0;
          if (iNewFrame) state <= SCAN;
        end
        SCAN: begin
          if (finishing) begin
            finishing <= 1'b0;
            state     <= DONE;
            oFound    <= locked;
            oTop      <= lock_top;
            oBottom   <= lock_bottom;
            oLeft     <= lock_left;
            oRight    <= lock_right;
            oMaxCount <= best;
            oMaxRow   <= best_row;
          end else if (frame_end) begin
            finishing <= 1'b1;
          end
        end
        DONE: begin
          if (iAck) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_roi_window_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_roi_window_detector
// Description : Directed self-checking bench for roi_window_detector on an
//               8x6 image with MIN_RUN=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_roi_window_detector;

  localparam int IMG_W   = 8;
  localparam int IMG_H   = 6;
  localparam int MIN_RUN = 2;
  localparam int COL_W   = $clog2(IMG_W);
  localparam int ROW_W   = $clog2(IMG_H);
  localparam int CNT_W   = $clog2(IMG_W + 1);

  logic             iCLK;
  logic             iRST_N;
  logic             iStart;
  logic             iAck;
  logic             iNewFrame;
  logic             iDATA;
  logic             iDVAL;
  logic [CNT_W-1:0] iThreshold;
  logic [1:0]       oState;
  logic             oDone;
  logic             oFound;
  logic [ROW_W-1:0] oTop;
  logic [ROW_W-1:0] oBottom;
  logic [COL_W-1:0] oLeft;
  logic [COL_W-1:0] oRight;
  logic [CNT_W-1:0] oMaxCount;
  logic [ROW_W-1:0] oMaxRow;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] img [IMG_H];

  roi_window_detector #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .MIN_RUN (MIN_RUN)
  ) dut (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .iStart     (iStart),
    .iAck       (iAck),
    .iNewFrame  (iNewFrame),
    .iDATA      (iDATA),
    .iDVAL      (iDVAL),
    .iThreshold (iThreshold),
    .oState     (oState),
    .oDone      (oDone),
    .oFound     (oFound),
    .oTop       (oTop),
    .oBottom    (oBottom),
    .oLeft      (oLeft),
    .oRight     (oRight),
    .oMaxCount  (oMaxCount),
    .oMaxRow    (oMaxRow)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input int found, input int top, input int bot,
                              input int left, input int right, input int maxc, input int maxr);
    check({tag, ".found"},  32'(oFound),    32'(found));
    check({tag, ".top"},    32'(oTop),      32'(top));
    check({tag, ".bottom"}, 32'(oBottom),   32'(bot));
    check({tag, ".left"},   32'(oLeft),     32'(left));
    check({tag, ".right"},  32'(oRight),    32'(right));
    check({tag, ".maxcnt"}, 32'(oMaxCount), 32'(maxc));
    check({tag, ".maxrow"}, 32'(oMaxRow),   32'(maxr));
  endtask

  task automatic clear_img();
    for (int r = 0; r < IMG_H; r++) img[r] = 8'h00;
  endtask

  task automatic arm(input string tag);
    @(negedge iCLK);
    iStart = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    check({tag, ".armed"}, 32'(oState), 32'd1);
  endtask

  // Stream npix pixels of img in raster order; first one carries iNewFrame.
  // With stall set, idle cycles carrying white data are inserted.
  task automatic send_pixels(input int npix, input bit stall);
    for (int p = 0; p < npix; p++) begin
      if (stall && (p % 5 == 2)) begin
        @(negedge iCLK);
        iNewFrame = 1'b0;
        iDVAL     = 1'b0;
        iDATA     = 1'b1;
      end
      @(negedge iCLK);
      iNewFrame = (p == 0);
      iDVAL     = 1'b1;
      iDATA     = img[p / IMG_W][p % IMG_W];
    end
  endtask

  task automatic end_frame(input string tag);
    @(negedge iCLK);
    iDVAL     = 1'b0;
    iNewFrame = 1'b0;
    iDATA     = 1'b0;
    check({tag, ".done_early"}, 32'(oDone), 32'd0);
    @(negedge iCLK);
    check({tag, ".done"},  32'(oDone),  32'd1);
    check({tag, ".state"}, 32'(oState), 32'd3);
  endtask

  task automatic ack(input string tag);
    @(negedge iCLK);
    iAck = 1'b1;
    @(negedge iCLK);
    iAck = 1'b0;
    check({tag, ".idle"}, 32'(oState), 32'd0);
  endtask

  initial begin
    iRST_N     = 1'b0;
    iStart     = 1'b0;
    iAck       = 1'b0;
    iNewFrame  = 1'b0;
    iDATA      = 1'b0;
    iDVAL      = 1'b0;
    iThreshold = 4'd2;
    clear_img();

    // Reset state
    repeat (2) @(negedge iCLK);
    check("rst.state", 32'(oState), 32'd0);
    check("rst.done",  32'(oDone),  32'd0);
    check_result("rst", 0, 0, 0, 0, 0, 0, 0);
    iRST_N = 1'b1;

    // Rows 2..4 white at cols 3..5
    arm("t2");
    img[2] = 8'b0011_1000;
    img[3] = 8'b0011_1000;
    img[4] = 8'b0011_1000;
    send_pixels(48, 1'b0);
    end_frame("t2");
    check_result("t2", 1, 2, 4, 3, 5, 3, 2);
    ack("t2");
    check_result("t2_held", 1, 2, 4, 3, 5, 3, 2);

    // Single full row (too short), then two-row run; stalls with white data
    arm("t3");
    clear_img();
    img[1] = 8'hFF;
    img[3] = 8'b0000_0110;
    img[4] = 8'b0000_0110;
    send_pixels(48, 1'b1);
    end_frame("t3");
    check_result("t3", 1, 3, 4, 1, 2, 8, 1);
    ack("t3");

    // All-black frame
    arm("t4");
    clear_img();
    send_pixels(48, 1'b0);
    end_frame("t4");
    check_result("t4", 0, 0, 0, 0, 0, 0, 0);
    ack("t4");
    check_result("t4_held", 0, 0, 0, 0, 0, 0, 0);

    // Frame A (would lock rows 0..1) aborted at row 3 by a new frame B
    arm("t5");
    clear_img();
    img[0] = 8'hFF;
    img[1] = 8'hFF;
    send_pixels(25, 1'b0);
    @(negedge iCLK);
    iDVAL  = 1'b0;
    iStart = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    check("t5.scan_ignores_start", 32'(oState), 32'd2);
    check("t5.no_done_midscan",    32'(oDone),  32'd0);
    clear_img();
    img[4] = 8'b1100_0000;
    img[5] = 8'b1100_0000;
    send_pixels(48, 1'b0);
    end_frame("t5");
    check_result("t5", 1, 4, 5, 6, 7, 2, 4);
    ack("t5");

    // All-white frame at the highest threshold; run open at frame end
    iThreshold = 4'd8;
    arm("t6");
    for (int r = 0; r < IMG_H; r++) img[r] = 8'hFF;
    send_pixels(48, 1'b0);
    end_frame("t6");
    check_result("t6", 1, 0, 5, 0, 7, 8, 0);
    ack("t6");

    // Asynchronous reset in the middle of a scan
    iThreshold = 4'd2;
    arm("t1");
    send_pixels(20, 1'b0);
    @(posedge iCLK);
    #2;
    iRST_N = 1'b0;
    #1;
    check("t1.state", 32'(oState), 32'd0);
    check("t1.done",  32'(oDone),  32'd0);
    check_result("t1", 0, 0, 0, 0, 0, 0, 0);
    @(negedge iCLK);
    iDVAL  = 1'b0;
    iDATA  = 1'b0;
    iRST_N = 1'b1;
    arm("t1_rearm");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
